// File: rtl/ldst_pkg.sv
// rtl/ldst_pkg.sv - shared opcodes and FSM states for the ld/sd fetch-decode stage
package ldst_pkg;

    localparam logic [6:0]  OPC_LOAD     = 7'b0000011;
    localparam logic [6:0]  OPC_STORE    = 7'b0100011;
    localparam logic [2:0]  F3_DOUBLE    = 3'b011;
    localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // S-type immediate is split across two fields of the instruction word
    function automatic logic [11:0] imm_s(input logic [31:0] instr);
        return {instr[31:25], instr[11:7]};
    endfunction

endpackage

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - 32-bit synchronous-read, single-write-port instruction RAM
module instr_mem #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ldst_fetch_decode.sv
// rtl/ldst_fetch_decode.sv - fetches RV64 words, decodes ld/sd and issues them downstream
module ldst_fetch_decode
    import ldst_pkg::*;
#(
    parameter int IMEM_AW = 8,
    parameter int PC_W    = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic               is_load,
    output logic               is_store,
    output logic [4:0]         base_reg,
    output logic [4:0]         data_reg,
    output logic [11:0]        offset,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               illegal
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] instr;
    logic        mem_we;
    logic        dec_load;
    logic        dec_store;
    logic        dec_ebreak;

    // The loader may only touch the RAM while nothing is being fetched
    assign mem_we = imem_we && ((state == ST_IDLE) || (state == ST_HALT));

    instr_mem #(
        .AW(IMEM_AW)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc[IMEM_AW+1:2]),
        .rdata (instr)
    );

    assign dec_load   = (instr[6:0] == OPC_LOAD)  && (instr[14:12] == F3_DOUBLE);
    assign dec_store  = (instr[6:0] == OPC_STORE) && (instr[14:12] == F3_DOUBLE);
    assign dec_ebreak = (instr == INSTR_EBREAK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        issue_valid = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = (dec_load || dec_store) ? ST_ISSUE : ST_HALT;
            ST_ISSUE: begin
                issue_valid = 1'b1;
                if (issue_ready) state_nxt = ST_FETCH;
            end
            ST_HALT:   if (start) state_nxt = ST_FETCH;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            is_load  <= 1'b0;
            is_store <= 1'b0;
            base_reg <= '0;
            data_reg <= '0;
            offset   <= '0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc       <= '0;
                        halted   <= 1'b0;
                        illegal  <= 1'b0;
                        is_load  <= 1'b0;
                        is_store <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    if (dec_load) begin
                        is_load  <= 1'b1;
                        is_store <= 1'b0;
                        base_reg <= instr[19:15];
                        data_reg <= instr[11:7];
                        offset   <= instr[31:20];
                    end else if (dec_store) begin
                        is_load  <= 1'b0;
                        is_store <= 1'b1;
                        base_reg <= instr[19:15];
                        data_reg <= instr[24:20];
                        offset   <= imm_s(instr);
                    end else begin
                        // pc is left on the word that stopped execution
                        halted  <= 1'b1;
                        illegal <= !dec_ebreak;
                    end
                end
                ST_ISSUE: begin
                    if (issue_ready) begin
                        pc <= pc + PC_W'(4);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
